// File: rtl/blood_anim_rom.sv
// blood_anim_rom: multi-frame blood-splatter sprite ROM with a built-in
// animation sequencer. A trigger starts playback at frame 0, and each frame is
// held for TICKS_PF video frame ticks. Pixel reads return a colour and a
// visibility flag one cycle after the address is presented.
//
// Build option: define BLOOD_ANIM_LOOP_EN to loop playback indefinitely.
// Without it, playback is one-shot: done pulses and the block returns to idle.
//
// The sprite image is generated by rom_word() so that the ROM has known
// contents without a load step. Each word is {frame+1, row[3:0], col[3:0]},
// and the key colour is placed on the diagonal where row == col. An empty
// INIT_FILE name selects a blank sprite in which every pixel is transparent.
module blood_anim_rom #(
  parameter int unsigned        ROW_W       = 6,
  parameter int unsigned        COL_W       = 6,
  parameter int unsigned        COLOR_W     = 12,
  parameter int unsigned        FRAMES      = 4,
  parameter int unsigned        FRAME_W     = 2,
  parameter int unsigned        TICKS_PF    = 6,
  parameter logic [COLOR_W-1:0] TRANSPARENT = 12'h000,
  parameter string              INIT_FILE   = "blood_anim.mem"
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               trigger,
  input  logic               stop,
  input  logic [ROW_W-1:0]   row,
  input  logic [COL_W-1:0]   col,
  output logic [COLOR_W-1:0] color_data,
  output logic               pixel_valid,
  output logic               busy,
  output logic               done
);

  localparam int unsigned AW     = FRAME_W + ROW_W + COL_W;
  localparam int unsigned TICK_W = (TICKS_PF > 1) ? $clog2(TICKS_PF) : 1;

  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(FRAMES - 1);
  localparam logic [TICK_W-1:0]  LAST_TICK  = TICK_W'(TICKS_PF - 1);
  localparam bit                 IMAGE_EN   = (INIT_FILE != "");

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [FRAME_W-1:0]   frame_idx;
  logic [FRAME_W-1:0]   frame_next;
  logic [TICK_W-1:0]    tick_cnt;
  logic [TICK_W-1:0]    tick_next;
  logic                 done_next;
  logic                 active_q;
  logic [AW-1:0]        rd_addr;
  logic [COLOR_W-1:0]   rom_q;

  // Sprite image: frame-major {frame,row,col}, with the key colour on the diagonal.
  function automatic logic [COLOR_W-1:0] rom_word(input logic [AW-1:0] addr);
    int unsigned f;
    int unsigned r;
    int unsigned c;
    int unsigned v;
    f = 32'(addr[AW-1 -: FRAME_W]);
    r = 32'(addr[COL_W +: ROW_W]);
    c = 32'(addr[COL_W-1:0]);
    v = ((f + 1) << 8) | ((r & 32'd15) << 4) | (c & 32'd15);
    if (!IMAGE_EN || (r == c)) begin
      rom_word = TRANSPARENT;
    end else begin
      rom_word = COLOR_W'(v);
    end
  endfunction

  // Sequencer next-state. Priority within PLAY is stop, then trigger, then frame_tick.
  always_comb begin
    state_next = state;
    frame_next = frame_idx;
    tick_next  = tick_cnt;
    done_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (trigger && !stop) begin
          state_next = PLAY;
          frame_next = '0;
          tick_next  = '0;
        end
      end
      PLAY: begin
        if (stop) begin
          state_next = IDLE;
          frame_next = '0;
          tick_next  = '0;
        end else if (trigger) begin
          frame_next = '0;
          tick_next  = '0;
        end else if (frame_tick) begin
          if (tick_cnt == LAST_TICK) begin
            tick_next = '0;
            if (frame_idx == LAST_FRAME) begin
`ifdef BLOOD_ANIM_LOOP_EN
              frame_next = '0;
`else
              frame_next = '0;
              state_next = IDLE;
              done_next  = 1'b1;
`endif
            end else begin
              frame_next = frame_idx + 1'b1;
            end
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        frame_next = '0;
        tick_next  = '0;
      end
    endcase
  end

  // Sequencer registers. busy is taken from the next state so that it tracks state exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      frame_idx <= '0;
      tick_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      frame_idx <= frame_next;
      tick_cnt  <= tick_next;
      busy      <= (state_next == PLAY);
      done      <= done_next;
    end
  end

  // The read address uses the registered frame index, so the pixel in flight keeps its own frame.
  always_comb begin
    rd_addr = {frame_idx, row, col};
  end

  // Synchronous ROM read. The output register is not reset, in the style of a block ROM.
  always_ff @(posedge clk) begin
    rom_q <= rom_word(rd_addr);
  end

  // Activity flag that travels alongside the ROM read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
    end else begin
      active_q <= (state == PLAY);
    end
  end

  // Output mux: report the key colour whenever the sprite is inactive.
  always_comb begin
    color_data  = active_q ? rom_q : TRANSPARENT;
    pixel_valid = active_q && (rom_q != TRANSPARENT);
  end

endmodule
